// File: rtl/clock_pkg.sv
// Shared state encodings and time-range constants for the clock setters
// and display decoders.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SET_HOUR     = 2'd1,
        SET_MINUTE   = 2'd2,
        SET_MERIDIEM = 2'd3
    } set_state_e;

    localparam logic [5:0] MINUTE_MAX = 6'd59;
    localparam logic [3:0] HOUR12_MAX = 4'd12;
    localparam logic [3:0] HOUR12_MIN = 4'd1;
    localparam logic [4:0] NOON24     = 5'd12;
    localparam logic [4:0] HOUR24_MAX = 5'd23;

endpackage

// File: rtl/set12_transmitter_if.sv
// extern12 propagate bus: edited 12-hour time plus a one-cycle load strobe
// toward the 24-hour clock.
interface set12_transmitter_if;
    logic       extern12_propagate;
    logic       extern12_isPM;
    logic [3:0] extern12_hours;
    logic [5:0] extern12_minutes;

    modport master (
        output extern12_propagate, extern12_isPM, extern12_hours, extern12_minutes
    );
    modport slave (
        input  extern12_propagate, extern12_isPM, extern12_hours, extern12_minutes
    );
endinterface

// File: rtl/set12_transmitter_hour24_to_12.sv
// Combinational 24h -> 12h hour mapping; out-of-range hours read as 12 AM.
module hour24_to_12
    import clock_pkg::*;
(
    input  logic [4:0] hours24,
    output logic [3:0] hours12,
    output logic       is_pm
);

    always_comb begin
        hours12 = HOUR12_MAX;
        is_pm   = 1'b0;
        if (hours24 == 5'd0 || hours24 > HOUR24_MAX) begin
            hours12 = HOUR12_MAX;
            is_pm   = 1'b0;
        end else if (hours24 < NOON24) begin
            hours12 = hours24[3:0];
        end else if (hours24 == NOON24) begin
            hours12 = HOUR12_MAX;
            is_pm   = 1'b1;
        end else begin
            hours12 = 4'(hours24 - NOON24);
            is_pm   = 1'b1;
        end
    end

endmodule

// File: rtl/set12_transmitter.sv
// 12-hour time-setting front end: captures the running 24h time, lets the
// user edit it, and commits it with a single-cycle propagate pulse.
module set12_transmitter
    import clock_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        setEnable,
    input  logic                        pulsed_set,
    input  logic                        pulsed_up,
    input  logic                        pulsed_down,
    input  logic [4:0]                  in24_hours,
    input  logic [5:0]                  in24_minutes,
    output logic [1:0]                  current_state,
    set12_transmitter_if.master         ext
);

    set_state_e state_q, state_d;
    logic [3:0] hours_q;
    logic [5:0] minutes_q;
    logic       is_pm_q;
    logic       prop_q;

    logic [3:0] cap_hours;
    logic       cap_pm;
    logic [5:0] cap_minutes;
    logic       adj;

    hour24_to_12 u_conv (
        .hours24 (in24_hours),
        .hours12 (cap_hours),
        .is_pm   (cap_pm)
    );

    assign cap_minutes = (in24_minutes > MINUTE_MAX) ? 6'd0 : in24_minutes;
    // Simultaneous up and down cancel out.
    assign adj = pulsed_up ^ pulsed_down;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!setEnable) begin
            state_d = IDLE;
        end else if (pulsed_set) begin
            unique case (state_q)
                IDLE:         state_d = SET_HOUR;
                SET_HOUR:     state_d = SET_MINUTE;
                SET_MINUTE:   state_d = SET_MERIDIEM;
                SET_MERIDIEM: state_d = IDLE;
                default:      state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hours_q   <= HOUR12_MAX;
            minutes_q <= 6'd0;
            is_pm_q   <= 1'b0;
            prop_q    <= 1'b0;
        end else begin
            prop_q <= 1'b0;
            if (setEnable) begin
                if (pulsed_set) begin
                    if (state_q == IDLE) begin
                        hours_q   <= cap_hours;
                        minutes_q <= cap_minutes;
                        is_pm_q   <= cap_pm;
                    end
                    if (state_q == SET_MERIDIEM) prop_q <= 1'b1;
                end else if (adj) begin
                    unique case (state_q)
                        SET_HOUR: begin
                            if (pulsed_up)
                                hours_q <= (hours_q == HOUR12_MAX) ? HOUR12_MIN : hours_q + 4'd1;
                            else
                                hours_q <= (hours_q == HOUR12_MIN) ? HOUR12_MAX : hours_q - 4'd1;
                        end
                        SET_MINUTE: begin
                            if (pulsed_up)
                                minutes_q <= (minutes_q == MINUTE_MAX) ? 6'd0 : minutes_q + 6'd1;
                            else
                                minutes_q <= (minutes_q == 6'd0) ? MINUTE_MAX : minutes_q - 6'd1;
                        end
                        SET_MERIDIEM: is_pm_q <= ~is_pm_q;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign current_state          = state_q;
    assign ext.extern12_propagate = prop_q;
    assign ext.extern12_isPM      = is_pm_q;
    assign ext.extern12_hours     = hours_q;
    assign ext.extern12_minutes   = minutes_q;

endmodule

// File: tb/tb_set12_transmitter.sv
// Directed bench for set12_transmitter with a cycle-level reference model.
module tb_set12_transmitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_en = 1'b1;
    logic       p_set = 1'b0, p_up = 1'b0, p_dn = 1'b0;
    logic [4:0] in_h = '0;
    logic [5:0] in_m = '0;
    logic [1:0] cur_state;

    set12_transmitter_if bus ();

    set12_transmitter dut (
        .clk           (clk),
        .reset         (rst_n),
        .setEnable     (set_en),
        .pulsed_set    (p_set),
        .pulsed_up     (p_up),
        .pulsed_down   (p_dn),
        .in24_hours    (in_h),
        .in24_minutes  (in_m),
        .current_state (cur_state),
        .ext           (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 12-hour time as plain integers, state as a 0..3 index.
    int m_state, m_h, m_m;
    bit m_pm, m_prop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0; m_h <= 12; m_m <= 0; m_pm <= 0; m_prop <= 0;
        end else begin
            m_prop <= 0;
            if (!set_en) begin
                m_state <= 0;
            end else if (p_set) begin
                if (m_state == 0) begin
                    if (int'(in_h) > 23) begin
                        m_h <= 12; m_pm <= 0;
                    end else begin
                        m_h  <= (int'(in_h) % 12 == 0) ? 12 : int'(in_h) % 12;
                        m_pm <= (int'(in_h) >= 12);
                    end
                    m_m <= (int'(in_m) > 59) ? 0 : int'(in_m);
                end
                if (m_state == 3) m_prop <= 1;
                m_state <= (m_state + 1) % 4;
            end else if (p_up != p_dn) begin
                if (m_state == 1) m_h <= ((m_h - 1 + (p_up ? 1 : 11)) % 12) + 1;
                if (m_state == 2) m_m <= (m_m + (p_up ? 1 : 59)) % 60;
                if (m_state == 3) m_pm <= !m_pm;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("model_state", int'(cur_state), m_state);
            check("model_hours", int'(bus.extern12_hours), m_h);
            check("model_minutes", int'(bus.extern12_minutes), m_m);
            check("model_isPM", int'(bus.extern12_isPM), int'(m_pm));
            check("model_propagate", int'(bus.extern12_propagate), int'(m_prop));
        end
    end

    // One-cycle pulse on the buttons; returns at the negedge after the sampling edge.
    task automatic pulse(input logic s, input logic u, input logic d);
        @(negedge clk);
        p_set = s; p_up = u; p_dn = d;
        @(negedge clk);
        p_set = 0; p_up = 0; p_dn = 0;
    endtask

    task automatic expect_out(input string name, input int st, input int h, input int m,
                              input int pm, input int pr);
        check({name, "_state"}, int'(cur_state), st);
        check({name, "_hours"}, int'(bus.extern12_hours), h);
        check({name, "_minutes"}, int'(bus.extern12_minutes), m);
        check({name, "_isPM"}, int'(bus.extern12_isPM), pm);
        check({name, "_prop"}, int'(bus.extern12_propagate), pr);
    endtask

    task automatic abort_to_idle();
        @(negedge clk);
        set_en = 0;
        @(negedge clk);
        set_en = 1;
    endtask

    int cap_h[4]  = '{0, 12, 13, 23};
    int exp_h[4]  = '{12, 12, 1, 11};
    int exp_pm[4] = '{0, 1, 1, 1};

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        cmp_en = 1;
        @(negedge clk);
        expect_out("reset", 0, 12, 0, 0, 0);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        expect_out("idle_updown", 0, 12, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            in_h = 5'(cap_h[i]); in_m = 6'd7;
            pulse(1, 0, 0);
            expect_out($sformatf("capture_%0d", cap_h[i]), 1, exp_h[i], 7, exp_pm[i], 0);
            abort_to_idle();
        end

        in_h = 5'd27; in_m = 6'd62;
        pulse(1, 0, 0);
        expect_out("capture_oor", 1, 12, 0, 0, 0);
        abort_to_idle();

        // Full edit session from 23:59.
        in_h = 5'd23; in_m = 6'd59;
        pulse(1, 0, 0);
        expect_out("cap2359", 1, 11, 59, 1, 0);
        pulse(0, 1, 0);
        check("hour_up_11_12", int'(bus.extern12_hours), 12);
        pulse(0, 1, 0);
        check("hour_up_12_1", int'(bus.extern12_hours), 1);
        check("hour_wrap_keeps_pm", int'(bus.extern12_isPM), 1);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("min_up_59_0", int'(bus.extern12_minutes), 0);
        pulse(0, 0, 1);
        check("min_down_0_59", int'(bus.extern12_minutes), 59);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("meridiem_toggle", int'(bus.extern12_isPM), 0);
        pulse(1, 0, 0);
        expect_out("commit", 0, 1, 59, 0, 1);
        @(negedge clk);
        expect_out("commit_after", 0, 1, 59, 0, 0);

        // Priority cases.
        in_h = 5'd10; in_m = 6'd30;
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        expect_out("updown_cancel", 1, 10, 30, 0, 0);
        pulse(1, 0, 0);
        pulse(1, 1, 0);
        expect_out("set_beats_up", 3, 10, 30, 0, 0);
        abort_to_idle();
        check("abort_from_meridiem", int'(cur_state), 0);

        // Abort from SET_MINUTE keeps edits and never propagates.
        in_h = 5'd5; in_m = 6'd15;
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        abort_to_idle();
        expect_out("abort_minute", 0, 5, 16, 0, 0);
        @(negedge clk);
        check("abort_no_prop", int'(bus.extern12_propagate), 0);

        // Reset in SET_MERIDIEM with a commit pending.
        in_h = 5'd18; in_m = 6'd45;
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        check("pre_reset_state", int'(cur_state), 3);
        @(negedge clk);
        p_set = 1;
        #2 rst_n = 0;
        #1 expect_out("async_reset", 0, 12, 0, 0, 0);
        @(negedge clk);
        p_set = 0;
        check("reset_held_prop", int'(bus.extern12_propagate), 0);
        rst_n = 1;
        @(negedge clk);
        expect_out("post_reset", 0, 12, 0, 0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
